inst_rom: RTL
=============

INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the memory depth in 32-bit words (power of two).
REQ-002 Parameter NOP_INS, default 32'h0000_0013, SHALL be the instruction returned whenever a fetch is not served from memory.
REQ-003 clki  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rsti  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 pc2rom  in  32  SHALL be the fetch byte address from the core.
REQ-006 rom_ins  out  32  SHALL be the instruction word returned for pc2rom.
REQ-007 ld_valid  in  1  SHALL indicate that a boot-load word is offered.
REQ-008 ld_data  in  32  SHALL carry the boot-load word.
REQ-009 ld_last  in  1  SHALL mark the final boot-load word (qualified by ld_valid).
REQ-010 ld_ready  out  1  SHALL indicate that the block accepts a load word this cycle.
REQ-011 boot_done  out  1  SHALL be high once loading has completed.
REQ-012 core_rstn  out  1  SHALL be the active-low reset for the core, released only after boot completes.
REQ-013 misalign_err  out  1  SHALL be a sticky flag for fetches with pc2rom[1:0] != 0.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD and RUN; reset SHALL enter IDLE.
REQ-015 IDLE: ld_ready=1; the first ld_valid SHALL write word 0 and move to LOAD, or move directly to RUN if ld_last is also high.
REQ-016 A load beat SHALL be accepted only when ld_valid && ld_ready; it SHALL write ld_data to mem[wr_cnt] and increment wr_cnt, which is ADDR_W=log2(DEPTH) bits wide.
REQ-017 LOAD: an accepted beat with ld_last=1, or an accepted beat at wr_cnt==DEPTH-1, SHALL transition to RUN on the same edge; wr_cnt SHALL NOT wrap.
REQ-018 RUN: ld_ready=0, boot_done=1, core_rstn=1; RUN SHALL persist until reset, and further ld_valid SHALL be ignored.
REQ-019 The fetch read SHALL be combinational (zero latency): rom_ins = mem[pc2rom[ADDR_W+1:2]] when in RUN, pc2rom[1:0]==0, and pc2rom < DEPTH*4.
REQ-020 Otherwise, rom_ins SHALL equal NOP_INS; this covers IDLE/LOAD, misaligned fetches, and out-of-range fetches.
REQ-021 misalign_err SHALL set on the clock edge in RUN when pc2rom[1:0] != 0, and SHALL clear only on reset.
REQ-022 Unloaded words SHALL read as the content left by the previous boot; no clear cycle SHALL be spent.
REQ-023 ld_valid held without ld_ready SHALL have no effect; ld_data need not be stable across unaccepted cycles.

Reset
REQ-024 On rsti=0, the block SHALL enter IDLE with wr_cnt=0, boot_done=0, core_rstn=0, misalign_err=0, ld_ready=0, and rom_ins=NOP_INS.
REQ-025 Reset in the middle of LOAD SHALL abandon the load and return to IDLE; memory contents SHALL be retained, and a reload SHALL restart at word 0.
REQ-026 ld_ready SHALL rise on the first clki edge after rsti deasserts.

Structure
REQ-027 NOP_INS and the FSM state encoding SHALL be in the shared package riscv_pkg.
REQ-028 The storage array SHALL be one sub-module, ins_mem (1 write port, 1 asynchronous read port), with the FSM and counter in inst_rom.

Verification
REQ-029 Load 4 words (0x00100093, 0x00200113, 0x002081B3, 0x00000013), with ld_last on the 4th -> boot_done=1 and core_rstn=1 on that edge; pc2rom=8 -> rom_ins=0x002081B3 in the same cycle.
REQ-030 pc2rom=0 during LOAD -> rom_ins=0x00000013, and core_rstn stays 0.
REQ-031 Load with DEPTH=4 and ld_last never asserted -> after 4 beats the state is RUN and ld_ready=0; a 5th ld_valid is ignored and mem[0] is unchanged.
REQ-032 In RUN, pc2rom=0x6 -> rom_ins=NOP and misalign_err=1 after the edge; it stays 1 when pc2rom returns to 0x4.
REQ-033 In RUN, pc2rom=DEPTH*4 -> rom_ins=0x00000013.
REQ-034 rsti=0 after 2 of 4 beats, then reload 0xAAAA0000 only with ld_last -> pc2rom=0 gives 0xAAAA0000 and pc2rom=4 gives the old word 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the instruction ROM (default NOP and boot FSM encoding)
package riscv_pkg;
    localparam logic [31:0] NOP_INS = 32'h0000_0013;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
endpackage

// File: rtl/ins_mem.sv
// ins_mem: word-wide storage with one synchronous write port and one asynchronous read port
module ins_mem #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);
    // No reset: contents deliberately survive a reboot
    logic [31:0] mem_q [DEPTH];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_rom.sv
// inst_rom: boot-loaded instruction memory; holds the core in reset until loading finishes
module inst_rom #(
    parameter int unsigned DEPTH   = 256,
    parameter logic [31:0] NOP_INS = riscv_pkg::NOP_INS
) (
    input  logic        clki,
    input  logic        rsti,
    input  logic [31:0] pc2rom,
    output logic [31:0] rom_ins,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        boot_done,
    output logic        core_rstn,
    output logic        misalign_err
);
    import riscv_pkg::*;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              rdy_q, mis_q, mis_d;
    logic              in_run, accept, at_end, hit;
    logic [31:0]       rd_data;
    assign in_run    = state_q == ST_RUN;
    // rdy_q delays ld_ready by one edge after reset release
    assign ld_ready  = rdy_q && !in_run;
    assign accept    = ld_valid && ld_ready;
    assign at_end    = ld_last || wr_cnt_q == LAST_ADDR;
    assign boot_done = in_run;
    assign core_rstn = in_run;
    assign misalign_err = mis_q;
    assign hit     = in_run && pc2rom[1:0] == 2'b00 && (pc2rom >> (ADDR_W + 2)) == 32'd0;
    assign rom_ins = hit ? rd_data : NOP_INS;
    always_comb begin
        state_d  = accept ? (at_end ? ST_RUN : ST_LOAD) : state_q;
        wr_cnt_d = (accept && wr_cnt_q != LAST_ADDR) ? wr_cnt_q + ADDR_W'(1) : wr_cnt_q;
        mis_d    = mis_q || (in_run && pc2rom[1:0] != 2'b00);
    end
    always_ff @(posedge clki or negedge rsti) begin
        if (!rsti) begin
            state_q  <= ST_IDLE;
            wr_cnt_q <= '0;
            rdy_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rdy_q    <= 1'b1;
            mis_q    <= mis_d;
        end
    end
    ins_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk_i   (clki),
        .we_i    (accept),
        .waddr_i (wr_cnt_q),
        .wdata_i (ld_data),
        .raddr_i (pc2rom[ADDR_W+1:2]),
        .rdata_o (rd_data)
    );
endmodule
